// File: rtl/merge_run_scheduler_if.sv
// Stream bundle for the two-way merge scheduler: two sorted input heads plus one output slot.
// The master side drives the input heads and out_ready; the slave side is the scheduler itself.
interface merge_run_scheduler_if #(
    parameter int DW    = 32,
    parameter int CNT_W = 16
);
    logic             a_valid;
    logic [DW-1:0]    a_data;
    logic             a_last;
    logic             a_ready;

    logic             b_valid;
    logic [DW-1:0]    b_data;
    logic             b_last;
    logic             b_ready;

    logic             valid;
    logic [DW-1:0]    data;
    logic             last;
    logic             out_ready;
    logic             stall;
    logic             switch_output;
    logic [CNT_W-1:0] runs_done;

    modport master (
        output a_valid, a_data, a_last,
        input  a_ready,
        output b_valid, b_data, b_last,
        input  b_ready,
        input  valid, data, last,
        output out_ready,
        input  stall, switch_output, runs_done
    );

    modport slave (
        input  a_valid, a_data, a_last,
        output a_ready,
        input  b_valid, b_data, b_last,
        output b_ready,
        output valid, data, last,
        input  out_ready,
        output stall, switch_output, runs_done
    );
endinterface

// File: rtl/merge_run_scheduler.sv
// Two-way merge scheduler: dequeues the smaller of two sorted heads each cycle into one registered
// output slot, drains the surviving run once the other ends, and marks/counts merged run ends.
module merge_run_scheduler #(
    parameter int DW    = 32,
    parameter int CNT_W = 16
) (
    input logic                  i_clk,
    input logic                  i_rst_n,
    merge_run_scheduler_if.slave bus
);
    typedef enum logic [1:0] {
        MERGE   = 2'd0,
        DRAIN_A = 2'd1,
        DRAIN_B = 2'd2
    } state_t;

    state_t           state;
    logic             valid_q;
    logic [DW-1:0]    data_q;
    logic             last_q;
    logic             switch_q;
    logic [CNT_W-1:0] runs_q;

    logic             load;
    logic             a_take;
    logic             b_take;
    logic             take;
    logic [DW-1:0]    take_data;
    logic             take_last;
    logic             xfer_last;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        load      = ~valid_q | bus.out_ready;
        a_take    = 1'b0;
        b_take    = 1'b0;
        if (i_rst_n && load) begin
            case (state)
                MERGE: begin
                    // Only merge with both heads present; ties go to A.
                    if (bus.a_valid && bus.b_valid) begin
                        a_take = (bus.a_data <= bus.b_data);
                        b_take = ~(bus.a_data <= bus.b_data);
                    end
                end
                DRAIN_A: a_take = bus.a_valid;
                DRAIN_B: b_take = bus.b_valid;
                default: ;
            endcase
        end
        take      = a_take | b_take;
        take_data = a_take ? bus.a_data : bus.b_data;
        take_last = a_take ? bus.a_last : bus.b_last;
    end

    assign xfer_last = valid_q & bus.out_ready & last_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= MERGE;
            valid_q  <= 1'b0;
            data_q   <= '0;
            last_q   <= 1'b0;
            switch_q <= 1'b0;
            runs_q   <= '0;
        end else begin
            // NOTE: registered state uses non-blocking assignments so every read sees pre-edge values.
            switch_q <= xfer_last;
            if (xfer_last) begin
                runs_q <= runs_q + CNT_W'(1);
            end

            if (load) begin
                valid_q <= take;
                if (take) begin
                    data_q <= take_data;
                    // The merged run only ends on the last tuple of the draining side.
                    last_q <= (state != MERGE) & take_last;
                end
            end

            if (take && take_last) begin
                case (state)
                    MERGE:   state <= a_take ? DRAIN_B : DRAIN_A;
                    default: state <= MERGE;
                endcase
            end
        end
    end

    assign bus.a_ready       = a_take;
    assign bus.b_ready       = b_take;
    assign bus.valid         = valid_q;
    assign bus.data          = data_q;
    assign bus.last          = last_q;
    assign bus.stall         = i_rst_n & valid_q & ~bus.out_ready;
    assign bus.switch_output = switch_q;
    assign bus.runs_done     = runs_q;
endmodule

// File: tb/tb_merge_run_scheduler.sv
// Directed bench for merge_run_scheduler: array-backed input streams, an output capture log,
// and hand-computed expected merge sequences.
module tb_merge_run_scheduler;
    localparam int DW    = 32;
    localparam int CNT_W = 2;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b0;

    merge_run_scheduler_if #(.DW(DW), .CNT_W(CNT_W)) ifc ();

    merge_run_scheduler #(.DW(DW), .CNT_W(CNT_W)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (ifc)
    );

    always #5 i_clk = ~i_clk;

    int tests = 0;
    int fails = 0;

    // Input streams: entries {last, data}; ptr advances on the DUT's ready.
    logic [32:0] a_mem [64];
    logic [32:0] b_mem [64];
    int a_len = 0, a_ptr = 0;
    int b_len = 0, b_ptr = 0;

    assign ifc.a_valid = (a_ptr < a_len);
    assign ifc.a_data  = a_mem[a_ptr[5:0]][31:0];
    assign ifc.a_last  = a_mem[a_ptr[5:0]][32];
    assign ifc.b_valid = (b_ptr < b_len);
    assign ifc.b_data  = b_mem[b_ptr[5:0]][31:0];
    assign ifc.b_last  = b_mem[b_ptr[5:0]][32];

    logic out_ready = 1'b1;
    assign ifc.out_ready = out_ready;

    always @(posedge i_clk) begin
        if (ifc.a_ready) a_ptr <= a_ptr + 1;
        if (ifc.b_ready) b_ptr <= b_ptr + 1;
    end

    // Output capture log.
    logic [32:0] got [64];
    int got_cyc [64];
    int got_n = 0;
    int cyc   = 0;

    always @(posedge i_clk) begin
        cyc <= cyc + 1;
        if (ifc.valid && ifc.out_ready && got_n < 64) begin
            got[got_n]     <= {ifc.last, ifc.data};
            got_cyc[got_n] <= cyc;
            got_n          <= got_n + 1;
        end
    end

    function automatic logic [32:0] mk(input logic last, input logic [31:0] data);
        return {last, data};
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_a(input logic [31:0] data, input logic last);
        a_mem[a_len[5:0]] = {last, data};
        a_len++;
    endtask

    task automatic push_b(input logic [31:0] data, input logic last);
        b_mem[b_len[5:0]] = {last, data};
        b_len++;
    endtask

    task automatic expect_out(input string tag, input int base, input int n,
                              input logic [32:0] e [8], input bit consec);
        int budget = 40;
        while (got_n < base + n && budget > 0) begin
            tick();
            budget--;
        end
        check({tag, " count"}, got_n - base, n);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s[%0d]", tag, i), got[base + i], e[i]);
            if (consec && i > 0)
                check($sformatf("%s gap[%0d]", tag, i), got_cyc[base + i] - got_cyc[base], i);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [32:0] e [8];
        int base;

        for (int i = 0; i < 64; i++) begin
            a_mem[i] = '0;
            b_mem[i] = '0;
        end

        // Reset state.
        repeat (2) tick();
        check("rst valid", ifc.valid, 0);
        check("rst data", ifc.data, 0);
        check("rst last", ifc.last, 0);
        check("rst switch", ifc.switch_output, 0);
        check("rst runs", ifc.runs_done, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        tick();

        // Test 1: basic interleaved merge at full throughput.
        base = got_n;
        push_a(1, 0); push_a(4, 0); push_a(7, 1);
        push_b(2, 0); push_b(3, 0); push_b(9, 1);
        e = '{mk(0, 1), mk(0, 2), mk(0, 3), mk(0, 4), mk(0, 7), mk(1, 9), '0, '0};
        expect_out("t1", base, 6, e, 1'b1);
        check("t1 switch", ifc.switch_output, 1);
        check("t1 runs", ifc.runs_done, 1);
        tick();
        check("t1 switch end", ifc.switch_output, 0);

        // Test 2: ties favour A; B5 closes the run.
        base = got_n;
        push_a(5, 0); push_a(5, 1);
        push_b(5, 1);
        @(negedge i_clk);
        check("t2 rdy0", {ifc.a_ready, ifc.b_ready}, 2'b10);
        tick();
        @(negedge i_clk);
        check("t2 rdy1", {ifc.a_ready, ifc.b_ready}, 2'b10);
        tick();
        @(negedge i_clk);
        check("t2 rdy2", {ifc.a_ready, ifc.b_ready}, 2'b01);
        e = '{mk(0, 5), mk(0, 5), mk(1, 5), '0, '0, '0, '0, '0};
        expect_out("t2", base, 3, e, 1'b1);
        check("t2 runs", ifc.runs_done, 2);
        tick();

        // Test 3: three-cycle downstream stall mid-run.
        base = got_n;
        push_a(1, 0); push_a(4, 0); push_a(7, 1);
        push_b(2, 0); push_b(3, 0); push_b(9, 1);
        tick();
        tick();
        check("t3 pre data", {ifc.valid, ifc.last, ifc.data}, {2'b10, 32'd2});
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            check($sformatf("t3 stall[%0d]", i), {ifc.stall, ifc.a_ready, ifc.b_ready}, 3'b100);
            check($sformatf("t3 hold[%0d]", i), {ifc.valid, ifc.last, ifc.data}, {2'b10, 32'd2});
            tick();
        end
        out_ready = 1'b1;
        @(negedge i_clk);
        check("t3 unstall", ifc.stall, 0);
        e = '{mk(0, 1), mk(0, 2), mk(0, 3), mk(0, 4), mk(0, 7), mk(1, 9), '0, '0};
        expect_out("t3", base, 6, e, 1'b0);
        check("t3 runs", ifc.runs_done, 3);
        tick();

        // Test 4: only A valid in MERGE -> no dequeue until B arrives.
        base = got_n;
        push_a(8, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge i_clk);
            check($sformatf("t4 idle[%0d]", i), {ifc.a_ready, ifc.b_ready, ifc.valid}, 3'b000);
            tick();
        end
        push_b(6, 1);
        @(negedge i_clk);
        check("t4 resume rdy", {ifc.a_ready, ifc.b_ready}, 2'b01);
        tick();
        check("t4 resume out", {ifc.valid, ifc.data}, {1'b1, 32'd6});
        e = '{mk(0, 6), mk(1, 8), '0, '0, '0, '0, '0, '0};
        expect_out("t4", base, 2, e, 1'b1);
        check("t4 runs wrap", ifc.runs_done, 0);
        tick();

        // Test 5: four single-tuple run pairs; counter wraps 1,2,3,0.
        base = got_n;
        push_a(10, 1); push_a(45, 1); push_a(50, 1); push_a(70, 1);
        push_b(20, 1); push_b(40, 1); push_b(60, 1); push_b(80, 1);
        tick();
        tick();
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("t5 pulse[%0d]", k), {ifc.switch_output, ifc.runs_done}, {1'b1, 2'(k % 4)});
            tick();
            check($sformatf("t5 gap[%0d]", k), ifc.switch_output, 0);
        end
        e = '{mk(0, 10), mk(1, 20), mk(0, 40), mk(1, 45), mk(0, 50), mk(1, 60), mk(0, 70), mk(1, 80)};
        expect_out("t5", base, 8, e, 1'b1);

        // Test 6: async reset while DRAIN_A holds a valid tuple.
        push_a(1, 1); push_a(100, 0); push_a(200, 1);
        push_b(2, 1); push_b(3, 1); push_b(7, 1);
        repeat (4) tick();
        check("t6 pre", {ifc.valid, ifc.data, ifc.runs_done}, {1'b1, 32'd100, 2'd1});
        out_ready = 1'b0;
        @(negedge i_clk);
        #1;
        i_rst_n = 1'b0;
        #1;
        check("t6 valid", ifc.valid, 0);
        check("t6 data", ifc.data, 0);
        check("t6 runs", ifc.runs_done, 0);
        check("t6 comb", {ifc.a_ready, ifc.b_ready, ifc.stall}, 3'b000);
        a_len = a_ptr;
        b_len = b_ptr;
        out_ready = 1'b1;
        #3;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        tick();
        check("t6 post", {ifc.valid, ifc.runs_done}, 3'b000);
        base = got_n;
        push_a(1, 1);
        push_b(2, 1);
        e = '{mk(0, 1), mk(1, 2), '0, '0, '0, '0, '0, '0};
        expect_out("t6", base, 2, e, 1'b1);
        check("t6 runs after", ifc.runs_done, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
